// File: rtl/bt_resp_rcv.sv
// bt_resp_rcv
//   Receive path for the Bluetooth module's serial responses. It deserialises
//   8N1 UART frames on RX and gathers the bytes of one response line into an
//   8-entry buffer. A carriage return ends the line and pulses resp_rcvd,
//   which tells the command sender it may issue the next command.
//
// Parameters
//   BAUD_DIV  clk cycles per bit (even, >= 8); 2604 = 50 MHz / 19200 baud
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   RX         asynchronous serial input, idle high
//   clr_resp   one-cycle flush of the line buffer (resp_len and ovfl)
//   rd_idx     buffer read index
//   rd_data    buf[rd_idx], or 0x00 when rd_idx >= resp_len
//   resp_len   number of stored bytes, 0..8
//   resp_rcvd  one-cycle pulse when a CR byte is received
//   frm_err    one-cycle pulse when a stop bit is sampled low
//   ovfl       sticky: a byte arrived while the buffer was full
module bt_resp_rcv #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_resp,
  input  logic [2:0] rd_idx,
  output logic [7:0] rd_data,
  output logic [3:0] resp_len,
  output logic       resp_rcvd,
  output logic       frm_err,
  output logic       ovfl
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t            state_q, state_d;
  logic              rx_s1_q, rx_s1_d;
  logic              rx_s2_q, rx_s2_d;
  logic [1:0]        sync_vld_q, sync_vld_d;
  logic              rx_hi_q, rx_hi_d;
  logic [CW-1:0]     baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0][7:0]   line_buf_q, line_buf_d;
  logic [3:0]        resp_len_q, resp_len_d;
  logic              resp_rcvd_q, resp_rcvd_d;
  logic              frm_err_q, frm_err_d;
  logic              ovfl_q, ovfl_d;

  logic              fall;
  logic              baud_zero;
  logic              byte_ok;

  // rx_hi_q only follows the synchronised line once both synchroniser flops
  // hold genuine post-reset samples. Their reset value of 1 would otherwise
  // fake a high->low edge when reset releases with the line held low.
  assign fall      = rx_hi_q & ~rx_s2_q;
  assign baud_zero = (baud_cnt_q == '0);

  always_comb begin
    rx_s1_d     = RX;
    rx_s2_d     = rx_s1_q;
    sync_vld_d  = {sync_vld_q[0], 1'b1};
    rx_hi_d     = sync_vld_q[1] & rx_s2_q;
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    line_buf_d  = line_buf_q;
    resp_len_d  = resp_len_q;
    resp_rcvd_d = 1'b0;
    frm_err_d   = 1'b0;
    ovfl_d      = ovfl_q;
    byte_ok     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          baud_cnt_d = HALF_LOAD;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (!baud_zero) begin
          baud_cnt_d = baud_cnt_q - CNT_ONE;
        end else if (!rx_s2_q) begin
          baud_cnt_d = FULL_LOAD;
          bit_cnt_d  = 3'd0;
          state_d    = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!baud_zero) begin
          baud_cnt_d = baud_cnt_q - CNT_ONE;
        end else begin
          shift_d    = {rx_s2_q, shift_q[7:1]};
          baud_cnt_d = FULL_LOAD;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (!baud_zero) begin
          baud_cnt_d = baud_cnt_q - CNT_ONE;
        end else begin
          state_d = ST_IDLE;
          if (rx_s2_q) begin
            byte_ok = 1'b1;
          end else begin
            frm_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (byte_ok) begin
      if (shift_q == 8'h0D) begin
        resp_rcvd_d = 1'b1;
      end else if (shift_q != 8'h0A) begin
        if (resp_len_q < 4'd8) begin
          if (!clr_resp) begin
            line_buf_d[resp_len_q[2:0]] = shift_q;
          end
          resp_len_d = resp_len_q + 4'd1;
        end else begin
          ovfl_d = 1'b1;
        end
      end
    end

    // Flush overrides any store or overflow from a byte accepted this cycle.
    if (clr_resp) begin
      resp_len_d = 4'd0;
      ovfl_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      sync_vld_q  <= '0;
      rx_hi_q     <= 1'b0;
      state_q     <= ST_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      line_buf_q  <= '0;
      resp_len_q  <= '0;
      resp_rcvd_q <= 1'b0;
      frm_err_q   <= 1'b0;
      ovfl_q      <= 1'b0;
    end else begin
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      sync_vld_q  <= sync_vld_d;
      rx_hi_q     <= rx_hi_d;
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      line_buf_q  <= line_buf_d;
      resp_len_q  <= resp_len_d;
      resp_rcvd_q <= resp_rcvd_d;
      frm_err_q   <= frm_err_d;
      ovfl_q      <= ovfl_d;
    end
  end

  assign rd_data   = ({1'b0, rd_idx} < resp_len_q) ? line_buf_q[rd_idx] : 8'h00;
  assign resp_len  = resp_len_q;
  assign resp_rcvd = resp_rcvd_q;
  assign frm_err   = frm_err_q;
  assign ovfl      = ovfl_q;

endmodule

// File: tb/tb_bt_resp_rcv.sv
// tb_bt_resp_rcv
//   Directed bench for bt_resp_rcv with BAUD_DIV = 16. Frames are driven on RX
//   one posedge + 1 time unit after a reference edge P0; with that alignment the
//   stop sample falls in the cycle P154..P155 and the registered results are
//   visible from P155, i.e. 155 counted edges after the frame's start count.
module tb_bt_resp_rcv;

  localparam int unsigned BD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       clr_resp;
  logic [2:0] rd_idx;
  logic [7:0] rd_data;
  logic [3:0] resp_len;
  logic       resp_rcvd;
  logic       frm_err;
  logic       ovfl;

  bt_resp_rcv #(.BAUD_DIV(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .clr_resp  (clr_resp),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .resp_len  (resp_len),
    .resp_rcvd (resp_rcvd),
    .frm_err   (frm_err),
    .ovfl      (ovfl)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rcvd_cnt = 0;
  int rcvd_cyc = 0;
  int ferr_cnt = 0;
  int ferr_cyc = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (resp_rcvd) begin
      rcvd_cnt <= rcvd_cnt + 1;
      rcvd_cyc <= cyc;
    end
    if (frm_err) begin
      ferr_cnt <= ferr_cnt + 1;
      ferr_cyc <= cyc;
    end
    if (resp_rcvd && frm_err) both_cnt <= both_cnt + 1;
  end

  int errors = 0;
  int checks = 0;
  int last_start = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [7:0] exp);
    rd_idx = idx;
    #1;
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic clr_pulse();
    clr_resp = 1'b1;
    tick(1);
    clr_resp = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 exactly 10 bit times later with
  // RX high, so consecutive calls give zero idle time between frames.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input logic clr_on_accept);
    last_start = cyc;
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BD);
    end
    RX = stop_val;
    if (clr_on_accept) begin
      tick(10);
      clr_resp = 1'b1;
      tick(1);
      clr_resp = 1'b0;
      tick(5);
    end else begin
      tick(BD);
    end
    RX = 1'b1;
  endtask

  int r0;
  int f0;
  logic [7:0] b;

  initial begin
    rst      = 1'b1;
    RX       = 1'b1;
    clr_resp = 1'b0;
    rd_idx   = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_len",   {28'd0, resp_len}, 32'd0);
    chk("rst_rcvd",  {31'd0, resp_rcvd}, 32'd0);
    chk("rst_ferr",  {31'd0, frm_err}, 32'd0);
    chk("rst_ovfl",  {31'd0, ovfl}, 32'd0);
    rd_chk("rst_rd0", 3'd0, 8'h00);
    rst = 1'b0;
    tick(8);

    // Normal line "AOK" + CR, back to back
    send_frame(8'h41, 1'b1, 1'b0);
    send_frame(8'h4F, 1'b1, 1'b0);
    send_frame(8'h4B, 1'b1, 1'b0);
    send_frame(8'h0D, 1'b1, 1'b0);
    tick(2);
    chk("aok_rcvd_cnt", rcvd_cnt, 32'd1);
    chk("aok_rcvd_time", rcvd_cyc - last_start, 32'd155);
    chk("aok_ferr_cnt", ferr_cnt, 32'd0);
    chk("aok_len", {28'd0, resp_len}, 32'd3);
    rd_chk("aok_rd0", 3'd0, 8'h41);
    rd_chk("aok_rd1", 3'd1, 8'h4F);
    rd_chk("aok_rd2", 3'd2, 8'h4B);
    rd_chk("aok_rd3_masked", 3'd3, 8'h00);
    tick(1);

    // LF ignored, overflow after 8 bytes
    clr_pulse();
    tick(4);
    r0 = rcvd_cnt;
    for (int i = 0; i < 10; i++) send_frame(8'h30 + 8'(i), 1'b1, 1'b0);
    send_frame(8'h0A, 1'b1, 1'b0);
    send_frame(8'h0D, 1'b1, 1'b0);
    tick(2);
    chk("ovf_len", {28'd0, resp_len}, 32'd8);
    chk("ovf_flag", {31'd0, ovfl}, 32'd1);
    chk("ovf_rcvd_cnt", rcvd_cnt, r0 + 1);
    rd_chk("ovf_rd7", 3'd7, 8'h37);
    rd_chk("ovf_rd0", 3'd0, 8'h30);
    tick(1);
    clr_pulse();
    chk("clr_len", {28'd0, resp_len}, 32'd0);
    chk("clr_ovfl", {31'd0, ovfl}, 32'd0);
    rd_chk("clr_rd0", 3'd0, 8'h00);
    tick(4);

    // Framing error
    r0 = rcvd_cnt;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    tick(2);
    chk("ferr_cnt", ferr_cnt, f0 + 1);
    chk("ferr_time", ferr_cyc - last_start, 32'd155);
    chk("ferr_no_rcvd", rcvd_cnt, r0);
    chk("ferr_len", {28'd0, resp_len}, 32'd0);
    tick(4);
    send_frame(8'h41, 1'b1, 1'b0);
    tick(2);
    chk("after_ferr_len", {28'd0, resp_len}, 32'd1);
    rd_chk("after_ferr_rd0", 3'd0, 8'h41);
    tick(1);

    // False start glitch
    f0 = ferr_cnt;
    RX = 1'b0;
    tick(4);
    RX = 1'b1;
    tick(20);
    send_frame(8'h42, 1'b1, 1'b0);
    tick(2);
    chk("glitch_ferr", ferr_cnt, f0);
    chk("glitch_rcvd", rcvd_cnt, r0);
    chk("glitch_len", {28'd0, resp_len}, 32'd2);
    rd_chk("glitch_rd1", 3'd1, 8'h42);
    tick(1);

    // clr_resp coincident with acceptance
    send_frame(8'h42, 1'b1, 1'b1);
    tick(2);
    chk("sim_len", {28'd0, resp_len}, 32'd0);
    rd_chk("sim_rd0", 3'd0, 8'h00);
    tick(1);
    send_frame(8'h43, 1'b1, 1'b0);
    tick(2);
    chk("sim_pre_cr_len", {28'd0, resp_len}, 32'd1);
    r0 = rcvd_cnt;
    send_frame(8'h0D, 1'b1, 1'b1);
    tick(2);
    chk("sim_cr_rcvd_cnt", rcvd_cnt, r0 + 1);
    chk("sim_cr_rcvd_time", rcvd_cyc - last_start, 32'd155);
    chk("sim_cr_len", {28'd0, resp_len}, 32'd0);
    tick(2);

    // Reset during DATA bit 4 of 0x46 (bit 4 is low, so RX stays low)
    send_frame(8'h44, 1'b1, 1'b0);
    tick(2);
    chk("pre_rst_len", {28'd0, resp_len}, 32'd1);
    b = 8'h46;
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 4; i++) begin
      RX = b[i];
      tick(BD);
    end
    RX = b[4];
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_len",  {28'd0, resp_len}, 32'd0);
    chk("mid_rst_rcvd", {31'd0, resp_rcvd}, 32'd0);
    chk("mid_rst_ferr", {31'd0, frm_err}, 32'd0);
    chk("mid_rst_ovfl", {31'd0, ovfl}, 32'd0);
    rd_chk("mid_rst_rd0", 3'd0, 8'h00);
    rst = 1'b0;
    r0 = rcvd_cnt;
    f0 = ferr_cnt;
    tick(2 * BD + 40);
    chk("low_hold_ferr", ferr_cnt, f0);
    chk("low_hold_len", {28'd0, resp_len}, 32'd0);
    RX = 1'b1;
    tick(20);
    send_frame(8'h47, 1'b1, 1'b0);
    tick(2);
    chk("post_rst_len", {28'd0, resp_len}, 32'd1);
    rd_chk("post_rst_rd0", 3'd0, 8'h47);
    chk("post_rst_ferr", ferr_cnt, f0);
    chk("post_rst_rcvd", rcvd_cnt, r0);
    chk("never_both", both_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bt_resp_rcv.md
# bt_resp_rcv

Receive path for the Bluetooth module's serial responses. It deserializes 8N1 UART frames on `RX` and collects the printable bytes of one response line into an 8-entry buffer. On carriage return it pulses `resp_rcvd`, which is the handshake the command sender waits on before issuing the next command. The block sits between the `RX` pin and the command sender, and exposes the captured line for optional inspection.

## Interface

- `BAUD_DIV`, default 2604, is the number of clk cycles per bit (50 MHz / 19200). Must be an even number ≥ 8.
- `clk`, input, 1 bit: system clock. All logic is on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `RX`, input, 1 bit: asynchronous serial line from the BT module. Idle level is high.
- `clr_resp`, input, 1 bit: one-cycle flush of the line buffer. The sender drives it when it launches a command.
- `rd_idx`, input, 3 bits: buffer read index.
- `rd_data`, output, 8 bits: combinational value of `buf[rd_idx]`. Reads 0x00 for `rd_idx` ≥ `resp_len`.
- `resp_len`, output, 4 bits: number of bytes stored, 0 to 8.
- `resp_rcvd`, output, 1 bit: one-cycle pulse when a CR (0x0D) byte completes.
- `frm_err`, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
- `ovfl`, output, 1 bit: sticky flag, set when a byte arrives while the buffer is full.

## Operation

**Reset and synchronization**
- `RX` passes through a 2-flop synchronizer. Both flops reset to 1.
- Reset values: `resp_len`=0, `resp_rcvd`=0, `frm_err`=0, `ovfl`=0, all buffer entries 0x00, state IDLE.

**State machine (IDLE, START, DATA, STOP)**
- **IDLE:** a synchronized high→low transition loads `baud_cnt`=BAUD_DIV/2−1 and moves to START.
- **START:** when `baud_cnt` reaches 0, sample the line.
  - Low: load `baud_cnt`=BAUD_DIV−1, set `bit_cnt`=0, go to DATA.
  - High: this is a false start. Return to IDLE with no output.
- **DATA:** at each `baud_cnt`=0, shift the sampled bit into `shift[7]` (LSB first), reload the counter, and increment `bit_cnt`. After bit 7, go to STOP.
- **STOP:** at `baud_cnt`=0, sample the stop bit and return to IDLE.
  - Stop bit low: pulse `frm_err` next cycle and discard the byte.
  - Stop bit high: the byte is accepted.

**Accepted byte handling** (the registered effects appear on the next cycle)
- **0x0D:** pulse `resp_rcvd`. Buffer and `resp_len` are unchanged, so the line stays readable.
- **0x0A:** ignored.
- **Any other byte with `resp_len` < 8:** write `buf[resp_len]` and increment `resp_len`.
- **Any other byte with `resp_len` = 8:** the byte is dropped and `ovfl` is set to 1.

**`clr_resp`**
- Sets `resp_len`=0 and `ovfl`=0. Buffer contents need not be cleared, because reads are masked by `resp_len`.
- It does not disturb a frame in progress.
- If it coincides with byte acceptance, the clear wins and the byte is dropped. If that byte was a CR, `resp_rcvd` still pulses.

**Reset during a frame:** returns immediately to IDLE with all reset values. If the line is still low, no new start is detected until a fresh high→low edge appears.

## Timing

- Let t0 be the cycle the synchronized falling edge is seen, which is 2–3 cycles after the pin edge.
- Start bit sample: t0 + BAUD_DIV/2.
- Data bit i sample: t0 + BAUD_DIV/2 + (i+1)·BAUD_DIV.
- Stop bit sample: t0 + BAUD_DIV/2 + 9·BAUD_DIV.
- `resp_rcvd`, `frm_err`, `resp_len` and `ovfl` update exactly one cycle after the stop sample.
- A new start edge is accepted from the cycle after the stop sample, so back-to-back frames with zero idle time are supported.
- `resp_rcvd` and `frm_err` are each high for exactly one cycle per frame. They are never both high together.
- `baud_cnt` is $clog2(BAUD_DIV) bits wide. `bit_cnt` is 3 bits and wraps 7→0 at the DATA→STOP transition.

## Test plan

All scenarios use BAUD_DIV=16.

- **Normal line:** send "AOK" then 0x0D, back to back. Expect `resp_len`=3 and `rd_data` values 0x41, 0x4F, 0x4B at idx 0–2. `resp_rcvd` is a single pulse exactly 1 cycle after the CR stop sample. `frm_err`=0 throughout.
- **LF and overflow:** send 10 non-CR bytes 0x30–0x39, then 0x0A, then 0x0D. Expect `resp_len`=8, `buf[7]`=0x37, `ovfl`=1 and one `resp_rcvd` pulse. A following `clr_resp` gives `resp_len`=0 and `ovfl`=0.
- **Framing error:** send 0x55 with the stop bit held low. Expect a one-cycle `frm_err` pulse, `resp_len` unchanged and no `resp_rcvd`. The next valid 0x41 stores normally.
- **False start:** apply a 4-cycle low glitch on `RX`. Expect a return to IDLE with no outputs. A valid frame starting 20 cycles later is received correctly.
- **Simultaneous events:** assert `clr_resp` in the same cycle byte 0x42 is accepted, with `resp_len`=2 beforehand. Expect `resp_len`=0 and 0x42 not stored. Repeat with a CR byte: expect `resp_rcvd` still pulses.
- **Reset mid-frame:** assert `rst` during DATA bit 4. Expect all outputs at their reset values the next cycle. A frame sent after `RX` returns high is received correctly.
